// File: rtl/adc_spi_responder.sv
// adc_spi_responder: SPI responder emulating one 8-channel, 12-bit ADC.
// A frame is 16 SCLK cycles. MOSI bits 3..5 of a frame select the channel
// whose result is returned in the next frame. MISO changes on SCLK falling
// edges. SCLK idles high.
// Optional feature macro: ADC_RESP_ERRCNT_EN enables the saturating
// aborted-frame counter on errCNT. Without it, errCNT is tied to zero.
module adc_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK7M,
    input  logic        RESET,
    input  logic        SCLK,
    input  logic        nCS,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_OE,
    input  logic        chWE,
    input  logic [2:0]  chADDR,
    input  logic [11:0] chDATA,
    output logic [2:0]  curCH,
    output logic        frameDONE,
    output logic [7:0]  errCNT
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] ncs_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sclk_prev_r;
    logic                   ncs_prev_r;

    logic sclk_s;
    logic ncs_s;
    logic mosi_s;
    logic sclk_rise_s;
    logic sclk_fall_s;
    logic ncs_rise_s;
    logic ncs_fall_s;

    state_t      state_r;
    state_t      state_s;
    logic [15:0] shift_r;
    logic [15:0] shift_s;
    logic [2:0]  ctrl_r;
    logic [2:0]  ctrl_s;
    logic [3:0]  bit_cnt_r;
    logic [3:0]  bit_cnt_s;
    logic        reload_r;
    logic        reload_s;
    logic [2:0]  next_ch_r;
    logic [2:0]  next_ch_s;
    logic [2:0]  cur_ch_r;
    logic [2:0]  cur_ch_s;
    logic        frame_done_r;
    logic        frame_done_s;
    logic        miso_r;
    logic        miso_s;
    logic        miso_oe_r;

    logic [11:0] ch_reg_r [0:7];

    assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync_r[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

    assign sclk_rise_s = sclk_s & ~sclk_prev_r;
    assign sclk_fall_s = ~sclk_s & sclk_prev_r;
    assign ncs_rise_s  = ncs_s & ~ncs_prev_r;
    assign ncs_fall_s  = ~ncs_s & ncs_prev_r;

    // Synchronize SPI inputs and keep the previous synchronized levels for edge detection.
    always_ff @(posedge CLK7M) begin
        if (RESET) begin
            sclk_sync_r <= {SYNC_STAGES{1'b1}};
            ncs_sync_r  <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            sclk_prev_r <= 1'b1;
            ncs_prev_r  <= 1'b1;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], SCLK};
            ncs_sync_r  <= {ncs_sync_r[SYNC_STAGES-2:0], nCS};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
            sclk_prev_r <= sclk_s;
            ncs_prev_r  <= ncs_s;
        end
    end

    // Channel register file. A load in the same cycle as a write reads the old value.
    always_ff @(posedge CLK7M) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) begin
                ch_reg_r[i] <= 12'h000;
            end
        end else if (chWE) begin
            ch_reg_r[chADDR] <= chDATA;
        end
    end

    // Frame FSM: next state, shift/control registers, counter and channel tracking.
    always_comb begin
        state_s      = state_r;
        shift_s      = shift_r;
        ctrl_s       = ctrl_r;
        bit_cnt_s    = bit_cnt_r;
        reload_s     = reload_r;
        next_ch_s    = next_ch_r;
        cur_ch_s     = cur_ch_r;
        frame_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                bit_cnt_s = 4'd0;
                reload_s  = 1'b0;
                if (ncs_fall_s) begin
                    state_s  = ST_SHIFT;
                    shift_s  = {4'h0, ch_reg_r[next_ch_r]};
                    cur_ch_s = next_ch_r;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (ncs_rise_s) begin
                    // A partial frame (counter nonzero) is dropped; nextCH is left alone.
                    state_s   = ST_IDLE;
                    bit_cnt_s = 4'd0;
                    reload_s  = 1'b0;
                end else if (sclk_rise_s) begin
                    // Rising edges 3..5 carry the next channel address, MSB first.
                    if ((bit_cnt_r >= 4'd2) && (bit_cnt_r <= 4'd4)) begin
                        ctrl_s = {ctrl_r[1:0], mosi_s};
                    end else begin
                        ctrl_s = ctrl_r;
                    end
                    if (bit_cnt_r == 4'd15) begin
                        bit_cnt_s    = 4'd0;
                        next_ch_s    = ctrl_r;
                        frame_done_s = 1'b1;
                        reload_s     = 1'b1;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end
                end else if (sclk_fall_s) begin
                    // The first falling edge of a frame presents bit 15: either
                    // a reload (back-to-back frame) or a hold (after nCS fall).
                    if (reload_r) begin
                        shift_s  = {4'h0, ch_reg_r[next_ch_r]};
                        cur_ch_s = next_ch_r;
                        reload_s = 1'b0;
                    end else if (bit_cnt_r != 4'd0) begin
                        shift_s = {shift_r[14:0], 1'b0};
                    end else begin
                        shift_s = shift_r;
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                bit_cnt_s = 4'd0;
                reload_s  = 1'b0;
            end
        endcase
        if (state_s == ST_SHIFT) begin
            miso_s = shift_s[15];
        end else begin
            miso_s = 1'b0;
        end
    end

    // Frame state and registered outputs.
    always_ff @(posedge CLK7M) begin
        if (RESET) begin
            state_r      <= ST_IDLE;
            shift_r      <= 16'h0000;
            ctrl_r       <= 3'd0;
            bit_cnt_r    <= 4'd0;
            reload_r     <= 1'b0;
            next_ch_r    <= 3'd0;
            cur_ch_r     <= 3'd0;
            frame_done_r <= 1'b0;
            miso_r       <= 1'b0;
            miso_oe_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            shift_r      <= shift_s;
            ctrl_r       <= ctrl_s;
            bit_cnt_r    <= bit_cnt_s;
            reload_r     <= reload_s;
            next_ch_r    <= next_ch_s;
            cur_ch_r     <= cur_ch_s;
            frame_done_r <= frame_done_s;
            miso_r       <= miso_s;
            miso_oe_r    <= ~ncs_s;
        end
    end

    assign MISO      = miso_r;
    assign MISO_OE   = miso_oe_r;
    assign curCH     = cur_ch_r;
    assign frameDONE = frame_done_r;

`ifdef ADC_RESP_ERRCNT_EN
    logic [7:0] err_cnt_r;
    logic       abort_s;

    assign abort_s = (state_r == ST_SHIFT) && ncs_rise_s && (bit_cnt_r != 4'd0);

    // Saturating count of aborted frames; cleared only by reset.
    always_ff @(posedge CLK7M) begin
        if (RESET) begin
            err_cnt_r <= 8'h00;
        end else if (abort_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'h01;
        end
    end

    assign errCNT = err_cnt_r;
`else
    assign errCNT = 8'h00;
`endif

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Synthesizable SPI responder that emulates one 8-channel, 12-bit A/D converter as seen by the HULOGIC2 SPI master (SCLK/MOSI/nCS in, MISO out). It lets hardware-in-the-loop rigs and the FPGA bench exercise the ADC acquisition path without real converters. Channel values come from an 8-entry register file loaded through a simple write port. The frame protocol is 16 SCLK per frame, channel address on MOSI, and result for the previously addressed channel on MISO.

## Interface
- SYNC_STAGES, 2, synchronizer depth for SCLK, nCS and MOSI; legal values 2..3.
- CLK7M  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- SCLK  in  1  SPI clock from master; idles high.
- nCS  in  1  SPI chip select, active low.
- MOSI  in  1  SPI data from master.
- MISO  out  1  SPI data to master; driven 0 when not selected.
- MISO_OE  out  1  high while the synchronized nCS is low; for an external tristate.
- chWE  in  1  channel register write strobe, one CLK7M cycle.
- chADDR  in  3  channel register index 0..7.
- chDATA  in  12  channel register value.
- curCH  out  3  channel whose result is being shifted in the current frame.
- frameDONE  out  1  one-cycle pulse when the 16th SCLK rising edge of a frame is detected.
- errCNT  out  8  count of aborted frames; present only with ADC_RESP_ERRCNT_EN.

## Operation
- **Input conditioning.** SCLK, nCS and MOSI pass through SYNC_STAGES flops. Edges of SCLK and nCS are detected on the synchronized signals. MOSI is sampled from the synchronized value in the same cycle that the SCLK rising edge is detected.
- **States:**
  - IDLE: nCS high. MISO=0. Bit counter=0.
  - SHIFT: frame in progress.
  - Only two states; transitions are driven only by synchronized nCS and SCLK edges.
- **IDLE→SHIFT (nCS falling edge):**
  - Load a 16-bit shift register with {4'b0, reg[nextCH]}.
  - Set curCH←nextCH.
  - MISO presents bit 15.
- **In SHIFT:**
  - On each SCLK falling edge, shift left; MISO = shift[15].
  - On each SCLK rising edge, capture MOSI into a control shifter and increment the bit counter.
  - Control bits 3..5 (rising edges 3, 4, 5, counting from 1; MSB first) form the address for the next frame.
- **16th rising edge:**
  - nextCH←captured address; pulse frameDONE; reset the counter to 0.
  - If nCS stays low, the next SCLK falling edge starts a new frame: reload the shift register from reg[nextCH] and update curCH. Continuous framing without nCS toggle is supported.
- **SHIFT→IDLE (nCS rising edge):**
  - Return to IDLE with MISO=0.
  - If the counter is not 0, the frame is aborted: nextCH is unchanged and errCNT is incremented.
- **Register file.**
  - chWE writes reg[chADDR]←chDATA at the clock edge.
  - A frame load in the same cycle as a write to the same index uses the old value.
  - Writes never disturb a shift already in progress, because data is snapshotted at load.
- **Reset values.** All channel registers 0, nextCH 0, curCH 0, MISO 0, MISO_OE 0, frameDONE 0, errCNT 0, state IDLE. Reset mid-frame abandons the frame and does not count it as an error.
- **Ignored edges.** SCLK edges while nCS is high are ignored.

## Timing
- **Latency, nCS to output.** From an nCS or SCLK input edge to its effect on MISO: SYNC_STAGES+1 CLK7M cycles maximum.
- **Master constraints.** SCLK high and low times must each be at least SYNC_STAGES+2 CLK7M periods. nCS falling edge to first SCLK falling edge must be at least the same.
- **Result pipeline.** The result for the channel addressed in frame N appears in frame N+1. The first frame after reset, or after any abort, returns channel nextCH (0 after reset).
- **frameDONE.** Asserted the cycle after the 16th rising edge is detected.
- **MISO_OE.** Follows synchronized nCS with one cycle of register delay.

## Configuration
- ADC_RESP_ERRCNT_EN defined:
  - errCNT is an 8-bit saturating counter (stops at 255) of aborted frames.
  - The counter is cleared only by RESET.
- Not defined: errCNT port is tied to 8'h00 and the counter logic is absent. Aborted frames still leave nextCH unchanged.

## Test plan
- **Pipelined read.** Reset; write ch0=0x123, ch3=0xABC. Frame 1 MOSI=0x1800 (address 3) → MISO=0x0123, curCH=0. Frame 2 → MISO=0x0ABC, curCH=3. frameDONE pulses once per frame.
- **Continuous framing.** Hold nCS low for 48 SCLK with addresses 5, 6, 7; ch5..7=0x555, 0x666, 0x777. The three results are ch(prev), 0x0555, 0x0666. No error count.
- **Abort.** Raise nCS after 9 SCLK in a frame addressing ch2 → nextCH unchanged. errCNT=1 with ADC_RESP_ERRCNT_EN, 0 without. The next full frame returns the previously pending channel.
- **Write collision.** chWE to ch4 with 0xFFF in the exact cycle of the nCS-fall load of ch4 (old 0x0AA) → MISO returns 0x00AA. The following frame addressing 4 returns 0x0FFF.
- **Reset mid-frame.** Assert RESET after 7 SCLK → MISO=0, MISO_OE=0, curCH=0, errCNT=0. The next frame returns reg[0]=0x000, since registers are cleared.
- **Saturation and idle noise.** Run 260 aborted frames → errCNT=255. Toggle SCLK with nCS high → no state change.
